aes128_pipe_enc: RTL and testbench
==================================

// Module: aes128_pipe_enc
// PURPOSE
//  Pipelined, handshaked AES-128 encryption engine; successor to the combinational unrolled core.
//  Rounds are split across NSTAGE = 10/RPS register stages: RPS=10 gives a 1-stage unrolled
//  engine, RPS=1 gives 10 stages and one block/cycle. Reuses sbox, shift_rows, mix_columns, key_expansion.
//  Sits between the host block FIFO and the ciphertext sink in the FPGA encryption datapath.
// PARAMETERS
//  RPS    10  rounds per pipeline stage; legal {1,2,5,10}, other values -> elaboration error
//  TAG_W  8   sideband tag width (used only when AES_TAG_EN is defined)
// PORTS
//  clk        in   1     single clock; all state on rising edge
//  rst        in   1     asynchronous, active-high reset
//  key_in     in   128   cipher key
//  key_load   in   1     1-cycle strobe: capture key_in into key register
//  key_err    out  1     1-cycle pulse: key_load rejected because busy=1
//  in_valid   in   1     plaintext block valid
//  in_ready   out  1     engine can accept block this cycle
//  in_data    in   128   plaintext, byte 0 = [127:120]
//  in_tag     in   TAG_W sideband tag (AES_TAG_EN only)
//  out_valid  out  1     ciphertext valid
//  out_ready  in   1     sink accepts ciphertext
//  out_data   out  128   ciphertext
//  out_tag    out  TAG_W tag of out_data block (AES_TAG_EN only)
//  busy       out  1     any stage holds a valid block
// BEHAVIOUR
//  Reset: all stage valids=0, stage data=0, key register=0, out_valid=0, out_data=0, out_tag=0,
//   key_err=0, busy=0. Reset mid-operation discards every in-flight block; no output for them.
//  Key: key_reg loads key_in on key_load & !busy; round keys derived combinationally from key_reg.
//   key_load & busy: key_reg unchanged, key_err=1 next cycle for one cycle.
//   in_ready forced 0 in any cycle key_load=1 (no block uses a half-updated key).
//  Stage s (0..NSTAGE-1) holds state after rounds 1..(s+1)*RPS. Stage 0 input = in_data ^ rk0.
//   Round 10 omits MixColumns. Last stage register drives out_data directly.
//  Handshake: transfer on valid&ready both sides. Stage s advances when its successor is empty or
//   advancing; last stage advances on out_ready. in_ready = !key_load & (!v0 | adv0).
//   Bubbles collapse: an empty stage always accepts from its predecessor.
//  Latency: accepted block appears on out_valid exactly NSTAGE cycles later if out_ready held 1.
//   Throughput: 1 block/cycle for every RPS.
//  Backpressure: out_ready=0 holds out_valid/out_data/out_tag stable; upstream fills, then in_ready=0
//   once all NSTAGE stages are full. Simultaneous accept at stage 0 and drain at last stage
//   when full is legal (no bubble). out_valid never drops without out_ready=1.
//  in_data ignored when in_valid=0; no X propagated into stage registers.
//  busy = OR of stage valids; combinational.
// CONFIGURATION
//  AES_TAG_EN defined: TAG_W tag register per stage, travels in lock-step with its block;
//   in_tag sampled on input transfer, out_tag valid with out_valid.
//  Undefined: in_tag/out_tag ports absent; no tag registers; all other behaviour identical.
// TESTING
//  T1 key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff
//     -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a exactly NSTAGE cycles after accept.
//  T2 key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734
//     -> 3925841d02dc09fbdc118597196a0b32; run for RPS=1,2,5,10.
//  T3 RPS=1, 64 back-to-back blocks, out_ready=1 -> 64 correct outputs, in order, on 64 consecutive cycles.
//  T4 out_ready=0 for 20 cycles with in_valid=1 -> in_ready=0 after NSTAGE accepts, out_data stable;
//     release -> all blocks drain in order, none lost or duplicated; tags (AES_TAG_EN) match blocks.
//  T5 key_load while busy=1 -> key_err pulse, key unchanged, in-flight outputs still match old key;
//     key_load with busy=0 -> next block uses new key.
//  T6 assert rst with 3 blocks in flight -> out_valid=0, busy=0 same cycle; after release T1 passes.

Source files
------------

// File: rtl/aes128_pipe_enc.sv
// aes128_pipe_enc -- pipelined AES-128 encryption engine with valid/ready flow control.
//
// The ten AES rounds are spread over NSTAGE = 10/RPS register stages (RPS = rounds per
// stage, legal values 1, 2, 5, 10). Round keys are expanded combinationally from a single
// key register. With the macro AES_TAG_EN defined, each stage also carries a TAG_W-bit
// sideband tag alongside its block; without it the tag ports and registers do not exist.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   key_in, key_load      key value and 1-cycle capture strobe (ignored while busy)
//   key_err               1-cycle pulse after a key_load that was rejected because busy=1
//   in_valid/in_ready     plaintext handshake, in_data byte 0 = [127:120]
//   in_tag                sideband tag sampled with the block (AES_TAG_EN only)
//   out_valid/out_ready   ciphertext handshake, out_data driven straight from the last stage
//   out_tag               tag belonging to out_data (AES_TAG_EN only)
//   busy                  some stage holds a valid block
//
// Handshake: a transfer happens on a cycle where valid and ready are both 1. A source
// never drops valid or changes its payload until the transfer happens; ready may depend
// combinationally on the consumer's own state but never on valid.
module aes128_pipe_enc #(
  parameter int RPS   = 10,
  parameter int TAG_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [127:0]       key_in,
  input  logic               key_load,
  output logic               key_err,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_data,
`ifdef AES_TAG_EN
  input  logic [TAG_W-1:0]   in_tag,
  output logic [TAG_W-1:0]   out_tag,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic               busy
);

  localparam int NSTAGE = (RPS > 0) ? 10 / RPS : 1;

  if (!(RPS == 1 || RPS == 2 || RPS == 5 || RPS == 10) || TAG_W < 1) begin : g_bad_cfg
    $error("aes128_pipe_enc: RPS must be 1, 2, 5 or 10 and TAG_W at least 1");
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, product of x^2 .. x^128) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] inv;
    t   = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      t   = gf_mul(t, t);
      inv = gf_mul(inv, t);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // All eleven round keys packed, round key 0 in the top 128 bits.
  function automatic logic [1407:0] key_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t    = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) key_expand[1407-32*i -: 32] = w[i];
  endfunction

  // One round: SubBytes, ShiftRows, MixColumns (skipped when last), AddRoundKey.
  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   b  [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[4*c+r] = b[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
      if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
      else      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o ^ k;
  endfunction

  logic [127:0]      key_q, key_d;
  logic              key_err_q, key_err_d;
  logic [1407:0]     rk_all;
  logic [NSTAGE-1:0] v_vec;
  logic [NSTAGE-1:0] rdy;

  assign rk_all = key_expand(key_q);

  for (genvar s = 0; s < NSTAGE; s++) begin : g_stg
    logic         v_q, v_d, prev_v;
    logic [127:0] d_q, d_d, prev_d, rnd;
`ifdef AES_TAG_EN
    logic [TAG_W-1:0] t_q, t_d, prev_t;
`endif

    if (s == 0) begin : g_head
      assign prev_v = in_valid & in_ready;
      assign prev_d = in_data ^ rk_all[1407 -: 128];
`ifdef AES_TAG_EN
      assign prev_t = in_tag;
`endif
    end else begin : g_body
      assign prev_v = g_stg[s-1].v_q;
      assign prev_d = g_stg[s-1].d_q;
`ifdef AES_TAG_EN
      assign prev_t = g_stg[s-1].t_q;
`endif
    end

    assign v_vec[s] = v_q;
    // A stage can take a new block unless it and every stage after it are full and the
    // sink is stalling; this is the unrolled form of "empty or successor ready".
    assign rdy[s] = out_ready | ~&v_vec[NSTAGE-1:s];

    always_comb begin
      rnd = prev_d;
      for (int r = 0; r < RPS; r++)
        rnd = aes_round(rnd, rk_all[1407-128*(s*RPS+r+1) -: 128], (s*RPS+r+1) == 10);
    end

    // Payload only moves when a real block arrives, so idle input data never lands here.
    always_comb begin
      v_d = v_q;
      d_d = d_q;
`ifdef AES_TAG_EN
      t_d = t_q;
`endif
      if (rdy[s]) begin
        v_d = prev_v;
        if (prev_v) begin
          d_d = rnd;
`ifdef AES_TAG_EN
          t_d = prev_t;
`endif
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        d_q <= '0;
`ifdef AES_TAG_EN
        t_q <= '0;
`endif
      end else begin
        v_q <= v_d;
        d_q <= d_d;
`ifdef AES_TAG_EN
        t_q <= t_d;
`endif
      end
    end
  end

  // The key only changes while the pipeline is empty, and no block is admitted on a
  // key_load cycle, so every block sees a single consistent key schedule.
  always_comb begin
    key_d     = key_q;
    key_err_d = 1'b0;
    if (key_load) begin
      if (busy) key_err_d = 1'b1;
      else      key_d     = key_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q     <= '0;
      key_err_q <= 1'b0;
    end else begin
      key_q     <= key_d;
      key_err_q <= key_err_d;
    end
  end

  assign busy      = |v_vec;
  assign in_ready  = ~key_load & rdy[0];
  assign key_err   = key_err_q;
  assign out_valid = v_vec[NSTAGE-1];
  assign out_data  = g_stg[NSTAGE-1].d_q;
`ifdef AES_TAG_EN
  assign out_tag   = g_stg[NSTAGE-1].t_q;
`endif

endmodule

// File: tb/tb_aes128_pipe_enc.sv
// Bench for aes128_pipe_enc: main instance RPS=1 (10 stages) with a textbook AES model and
// expected-ciphertext queue, plus RPS=2/5/10 instances used for the known-answer latency tests.
module tb_aes128_pipe_enc;
  localparam int NSTAGE = 10;
  localparam int TAG_W  = 8;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [127:0] key_in, in_data, out_data;
  logic         key_load, key_err, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]   x_ov, x_ir, x_ke, x_busy;
  logic [127:0] x_od [3];
`ifdef AES_TAG_EN
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [TAG_W-1:0] x_ot [3];
  logic [TAG_W-1:0] exp_t_q[$];
  logic [TAG_W-1:0] hold_tag;
`endif

  aes128_pipe_enc #(.RPS(1), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load), .key_err(key_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef AES_TAG_EN
    .in_tag(in_tag), .out_tag(out_tag),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

  for (genvar g = 0; g < 3; g++) begin : g_x
    aes128_pipe_enc #(.RPS(g == 0 ? 2 : (g == 1 ? 5 : 10)), .TAG_W(TAG_W)) u_x (
      .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load), .key_err(x_ke[g]),
      .in_valid(in_valid), .in_ready(x_ir[g]), .in_data(in_data),
`ifdef AES_TAG_EN
      .in_tag(in_tag), .out_tag(x_ot[g]),
`endif
      .out_valid(x_ov[g]), .out_ready(1'b1), .out_data(x_od[g]), .busy(x_busy[g]));
  end

  // ---------------- reference model ----------------
  logic [7:0] sbox_tab [256];

  function automatic int gmul(int a, int b);
    int p = 0;
    while (b != 0) begin
      if ((b & 1) != 0) p = p ^ a;
      a = a << 1;
      if ((a & 'h100) != 0) a = a ^ 'h11b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic void build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv, s;
      logic [7:0] c;
      inv = 8'h00;
      c = 8'h63;
      if (a != 0)
        for (int b = 1; b < 256; b++)
          if (gmul(a, b) == 1) begin inv = 8'(b); break; end
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tab[a] = s;
    end
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] kw [44][4];
    logic [7:0] st [4][4];
    logic [7:0] tm [4][4];
    logic [7:0] t [4];
    logic [127:0] res;
    int rc = 1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) kw[i][j] = key[127-32*i-8*j -: 8];
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) t[j] = kw[i-1][j];
      if (i % 4 == 0) begin
        for (int j = 0; j < 4; j++) t[j] = sbox_tab[kw[i-1][(j+1)%4]];
        t[0] = t[0] ^ 8'(rc);
        rc = gmul(rc, 2);
      end
      for (int j = 0; j < 4; j++) kw[i][j] = kw[i-4][j] ^ t[j];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) st[r][c] = pt[127-8*(4*c+r) -: 8] ^ kw[c][r];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) tm[r][c] = sbox_tab[st[r][(c+r)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (rnd == 10) st[r][c] = tm[r][c];
          else st[r][c] = 8'(gmul(2, tm[r][c]) ^ gmul(3, tm[(r+1)%4][c]))
                          ^ tm[(r+2)%4][c] ^ tm[(r+3)%4][c];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) st[r][c] = st[r][c] ^ kw[4*rnd+c][r];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) res[127-8*(4*c+r) -: 8] = st[r][c];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- scoreboard state ----------------
  logic [127:0] exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           inflight = 0;
  logic [127:0] key_m = '0;
  logic         kerr_pending = 1'b0;
  logic         free_run = 1'b1;
  logic [63:0]  acc_hist = '0;
  logic         hold_prev = 1'b0;
  logic [127:0] hold_data = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
`ifdef AES_TAG_EN
    exp_t_q.delete();
`endif
    inflight = 0; key_m = '0; kerr_pending = 1'b0;
    free_run = 1'b1; acc_hist = '0; hold_prev = 1'b0;
  endtask

  // ---------------- driver: one cycle, checks on the main instance ----------------
  task automatic step(input logic v, input logic [127:0] d, input logic ordy,
                      input logic kl, input logic [127:0] k);
    logic exp_rdy, acc, busy_now;
    @(negedge clk);
    in_valid = v; in_data = v ? d : rnd128(); out_ready = ordy; key_load = kl; key_in = k;
`ifdef AES_TAG_EN
    in_tag = TAG_W'($urandom);
`endif
    #1;
    busy_now = (inflight != 0);
    if (!busy_now) begin free_run = 1'b1; acc_hist = '0; end
    chk("busy", busy, busy_now);
    chk("key_err", key_err, kerr_pending);
    exp_rdy = !kl && (ordy || inflight < NSTAGE);
    chk("in_ready", in_ready, exp_rdy);
    if (free_run) chk("out_valid_latency", out_valid, acc_hist[NSTAGE-1]);
    if (hold_prev) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", out_data, hold_data);
`ifdef AES_TAG_EN
      chk("hold_tag", out_tag, hold_tag);
`endif
    end
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) chk("unexpected_out", out_valid, 1'b0);
      else begin
        chk("out_data", out_data, exp_q.pop_front());
`ifdef AES_TAG_EN
        chk("out_tag", out_tag, exp_t_q.pop_front());
`endif
        inflight--;
      end
    end
    acc = v && exp_rdy;
    if (acc) begin
      exp_q.push_back(model_enc(key_m, d));
`ifdef AES_TAG_EN
      exp_t_q.push_back(in_tag);
`endif
      inflight++;
    end
    if (kl && !busy_now) key_m = k;
    kerr_pending = kl && busy_now;
    if (!ordy && busy_now) free_run = 1'b0;
    hold_prev = out_valid && !ordy;
    hold_data = out_data;
`ifdef AES_TAG_EN
    hold_tag = out_tag;
`endif
    acc_hist = {acc_hist[62:0], acc};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, '0);
  endtask

  // Known answer on all four pipeline depths, each at its own exact latency.
  task automatic kat(input logic [127:0] k, input logic [127:0] pt, input logic [127:0] ct);
    int ns [3] = '{5, 2, 1};
    step(1'b0, '0, 1'b1, 1'b1, k);
    step(1'b1, pt, 1'b1, 1'b0, '0);
    for (int n = 1; n <= NSTAGE + 1; n++) begin
      step(1'b0, '0, 1'b1, 1'b0, '0);
      chk("kat_valid_rps1", out_valid, n == NSTAGE);
      if (n == NSTAGE) chk("kat_data_rps1", out_data, ct);
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("kat_valid_x%0d", g), x_ov[g], n == ns[g]);
        if (n == ns[g]) chk($sformatf("kat_data_x%0d", g), x_od[g], ct);
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; key_load = 1'b0; key_in = '0;
`ifdef AES_TAG_EN
    in_tag = '0;
`endif
    build_sbox();

    // reset state
    step(1'b0, '0, 1'b1, 1'b0, '0);
    chk("rst_out_data", out_data, 128'h0);
    step(1'b0, '0, 1'b1, 1'b0, '0);
    rst = 1'b0;

    // T1 / T2 known answers
    kat(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
        128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    kat(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
        128'h3925841d02dc09fbdc118597196a0b32);

    // T3: 64 back-to-back random blocks with a free-running sink
    for (int i = 0; i < 64; i++) step(1'b1, rnd128(), 1'b1, 1'b0, '0);
    idle(NSTAGE + 2);
    chk("t3_drain_left", exp_q.size(), 0);

    // T4: stall the sink while offering blocks, then release with simultaneous accept/drain
    for (int i = 0; i < 20; i++) step(1'b1, rnd128(), 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b1, rnd128(), 1'b1, 1'b0, '0);
    idle(NSTAGE + 4);
    chk("t4_drain_left", exp_q.size(), 0);

    // random traffic with random sink stalls
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 1)), rnd128(), $urandom_range(0, 3) != 0, 1'b0, '0);
    idle(NSTAGE + 4);
    chk("rand_drain_left", exp_q.size(), 0);

    // T5: key_load while busy is rejected; key_load while idle takes effect
    for (int i = 0; i < 4; i++) step(1'b1, rnd128(), 1'b0, 1'b0, '0);
    step(1'b1, rnd128(), 1'b0, 1'b1, rnd128());
    step(1'b0, '0, 1'b0, 1'b0, '0);
    idle(NSTAGE + 3);
    chk("t5_drain_left", exp_q.size(), 0);
    step(1'b1, rnd128(), 1'b1, 1'b1, rnd128());
    for (int i = 0; i < 3; i++) step(1'b1, rnd128(), 1'b1, 1'b0, '0);
    idle(NSTAGE + 2);
    chk("t5b_drain_left", exp_q.size(), 0);

    // T6: asynchronous reset with three blocks in flight
    for (int i = 0; i < 3; i++) step(1'b1, rnd128(), 1'b1, 1'b0, '0);
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_out_data", out_data, 128'h0);
    model_reset();
    step(1'b0, '0, 1'b1, 1'b0, '0);
    rst = 1'b0;
    idle(NSTAGE + 2);
    kat(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
        128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("final_drain_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
